ring_phase_monitor: RTL
=======================

RING_PHASE_MONITOR -- requirements
Module: ring_phase_monitor

Interface
REQ-001 SHALL have parameter N, default 4, ring width; legal N >= 2.
REQ-002 SHALL have parameter REV_W, default 8, revolution counter width.
REQ-003 SHALL have parameter SYNC_CYC, default 2, the maximum number of cycles in SYNC without a one-hot phase.
REQ-004 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port phase  input  N  one-hot ring vector from the upstream ring counter, which rotates bit i to bit i+1 and bit N-1 to bit 0 every clk.
REQ-007 SHALL have port err_clr  input  1  clears err_sticky.
REQ-008 SHALL have port idx  output  clog2(N)  binary index of the set phase bit.
REQ-009 SHALL have port idx_valid  output  1  idx is trustworthy (TRACK state).
REQ-010 SHALL have port rev_tick  output  1  one-cycle pulse per completed revolution.
REQ-011 SHALL have port rev_cnt  output  REV_W  revolution count, modulo 2^REV_W.
REQ-012 SHALL have port err_onehot  output  1  one-cycle pulse: phase is not one-hot.
REQ-013 SHALL have port err_seq  output  1  one-cycle pulse: phase is one-hot but not the expected rotation.
REQ-014 SHALL have port err_sticky  output  1  latched OR of all error pulses.
REQ-015 SHALL have port resync_req  output  1  level request to the upstream ring to re-preset; high while in FAULT.

Function
REQ-016 SHALL keep all outputs registered; phase sampled at edge t is reflected in outputs immediately after edge t, i.e. 1-cycle latency.
REQ-017 SHALL implement FSM states SYNC, TRACK and FAULT, with a prev register holding the last phase accepted in TRACK.
REQ-018 In SYNC, a one-hot phase SHALL cause a transition to TRACK, set idx to encode(phase) and idx_valid to 1, and set prev to phase; no rev_tick is issued.
REQ-019 In SYNC, SHALL count non-one-hot cycles; on the SYNC_CYC-th consecutive such cycle, SHALL pulse err_onehot and transition to FAULT.
REQ-020 In TRACK, expected = prev rotated left by one position (bit N-1 wraps to bit 0); phase == expected SHALL update idx and prev and stay in TRACK.
REQ-021 In TRACK, the accepted transition from idx N-1 to idx 0 SHALL pulse rev_tick and increment rev_cnt; rev_cnt SHALL wrap from 2^REV_W-1 to 0 silently.
REQ-022 In TRACK, a non-one-hot phase (zero or multi-bit) SHALL pulse err_onehot only and transition to FAULT.
REQ-023 In TRACK, a one-hot phase != expected SHALL pulse err_seq and transition to FAULT.
REQ-024 In FAULT, SHALL hold idx_valid=0 and resync_req=1 and keep idx frozen; phase == 1 (bit 0 only) SHALL transition to TRACK with idx=0, prev=phase and resync_req=0 on that edge; any other phase stays in FAULT with no further error pulses.
REQ-025 SHALL leave rev_cnt unchanged by SYNC and FAULT; it is cleared only by rst.
REQ-026 SHALL set err_sticky on any error pulse; err_clr clears it; if err_clr and an error pulse occur in the same cycle, set SHALL win.
REQ-027 SHALL never assert err_onehot and err_seq in the same cycle.

Reset
REQ-028 rst SHALL immediately, without a clock, force: state SYNC, prev 0, idx 0, idx_valid 0, rev_tick 0, rev_cnt 0, err_onehot 0, err_seq 0, err_sticky 0, resync_req 0, SYNC counter 0.
REQ-029 Reset asserted mid-TRACK or mid-FAULT SHALL discard all history; after release, behaviour SHALL be as from power-up.

Structure
REQ-030 Package ring_mon_pkg SHALL hold the FSM state encoding (SYNC, TRACK, FAULT) and the index-width constant function clog2.
REQ-031 SHALL contain one combinational sub-module onehot_enc (inputs: vector; outputs: binary index, is_onehot flag), instantiated once on phase.

Verification (N=4, REV_W=8, SYNC_CYC=2 unless stated)
REQ-032 Release rst, phase 0001,0010,0100,1000,0001 -> idx 0,1,2,3,0; idx_valid 1 from first edge; rev_tick only at 5th edge; rev_cnt=1.
REQ-033 In TRACK at idx 1, phase 0110 -> err_onehot 1 cycle, err_seq 0, err_sticky 1, idx_valid 0, resync_req 1; then phase 0001 -> TRACK, idx 0, resync_req 0.
REQ-034 In TRACK at 0001, phase 0100 -> err_seq 1 cycle, FAULT; phase 0010 held 3 cycles -> stays FAULT, no further pulses.
REQ-035 After rst, phase 0000 for 2 cycles -> err_onehot pulse on 2nd edge, FAULT, resync_req 1.
REQ-036 REV_W=2, run 4 clean revolutions -> rev_cnt 1,2,3,0 with 4 rev_tick pulses.
REQ-037 err_clr coincident with an err_seq pulse -> err_sticky stays 1; err_clr alone next cycle -> 0; rst asserted mid-TRACK between edges -> all outputs 0 before next edge.

Source files
------------

// File: rtl/ring_mon_pkg.sv
// Shared definitions for the ring phase monitor: FSM state encoding and
// the width helper used to size the phase index.
package ring_mon_pkg;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } mon_state_e;

  // Never returns 0 so that single-value ranges still get a 1-bit vector.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/ring_phase_monitor_onehot_enc.sv
// Combinational one-hot to binary encoder with a one-hot validity flag.
module onehot_enc
  import ring_mon_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]        vec_i,
  output logic [clog2(N)-1:0] idx_o,
  output logic                onehot_o
);

  localparam int unsigned IW = clog2(N);

  // OR of set-bit positions; only meaningful when onehot_o is high.
  always_comb begin
    idx_o = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (vec_i[i]) idx_o = idx_o | IW'(i);
    end
  end

  assign onehot_o = (vec_i != '0) && ((vec_i & (vec_i - N'(1))) == '0);

endmodule

// File: rtl/ring_phase_monitor.sv
// Monitors a rotating one-hot ring: tracks phase index, counts revolutions,
// flags corruption or mis-sequencing and requests a re-preset on fault.
module ring_phase_monitor
  import ring_mon_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned REV_W    = 8,
  parameter int unsigned SYNC_CYC = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        phase,
  input  logic                err_clr,
  output logic [clog2(N)-1:0] idx,
  output logic                idx_valid,
  output logic                rev_tick,
  output logic [REV_W-1:0]    rev_cnt,
  output logic                err_onehot,
  output logic                err_seq,
  output logic                err_sticky,
  output logic                resync_req
);

  localparam int unsigned IW = clog2(N);
  localparam int unsigned SW = clog2(SYNC_CYC + 1);

  mon_state_e        state_q;
  logic [N-1:0]      prev_q;
  logic [IW-1:0]     idx_q;
  logic              idx_valid_q;
  logic              rev_tick_q;
  logic [REV_W-1:0]  rev_cnt_q;
  logic              err_onehot_q;
  logic              err_seq_q;
  logic              err_sticky_q;
  logic              resync_req_q;
  logic [SW-1:0]     sync_cnt_q;

  logic [IW-1:0]     enc_idx;
  logic              is_onehot;
  logic [N-1:0]      expected;
  logic              err_oh_d;
  logic              err_sq_d;

  onehot_enc #(.N(N)) u_enc (
    .vec_i    (phase),
    .idx_o    (enc_idx),
    .onehot_o (is_onehot)
  );

  // Error pulses are decoded combinationally so the sticky flag can give
  // priority to a same-cycle error over err_clr.
  always_comb begin
    expected = {prev_q[N-2:0], prev_q[N-1]};
    err_oh_d = 1'b0;
    err_sq_d = 1'b0;
    case (state_q)
      SYNC:    err_oh_d = !is_onehot && (sync_cnt_q == SW'(SYNC_CYC - 1));
      TRACK: begin
        err_oh_d = !is_onehot;
        err_sq_d = is_onehot && (phase != expected);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= SYNC;
      prev_q       <= '0;
      idx_q        <= '0;
      idx_valid_q  <= 1'b0;
      rev_tick_q   <= 1'b0;
      rev_cnt_q    <= '0;
      err_onehot_q <= 1'b0;
      err_seq_q    <= 1'b0;
      err_sticky_q <= 1'b0;
      resync_req_q <= 1'b0;
      sync_cnt_q   <= '0;
    end else begin
      rev_tick_q   <= 1'b0;
      err_onehot_q <= err_oh_d;
      err_seq_q    <= err_sq_d;
      err_sticky_q <= err_oh_d | err_sq_d | (err_sticky_q & ~err_clr);
      case (state_q)
        SYNC: begin
          if (is_onehot) begin
            state_q     <= TRACK;
            idx_q       <= enc_idx;
            idx_valid_q <= 1'b1;
            prev_q      <= phase;
            sync_cnt_q  <= '0;
          end else if (err_oh_d) begin
            state_q      <= FAULT;
            resync_req_q <= 1'b1;
            sync_cnt_q   <= '0;
          end else begin
            sync_cnt_q <= sync_cnt_q + SW'(1);
          end
        end
        TRACK: begin
          if (err_oh_d || err_sq_d) begin
            state_q      <= FAULT;
            idx_valid_q  <= 1'b0;
            resync_req_q <= 1'b1;
          end else begin
            idx_q  <= enc_idx;
            prev_q <= phase;
            if (prev_q[N-1]) begin
              rev_tick_q <= 1'b1;
              rev_cnt_q  <= rev_cnt_q + REV_W'(1);
            end
          end
        end
        FAULT: begin
          if (phase == N'(1)) begin
            state_q      <= TRACK;
            idx_q        <= '0;
            idx_valid_q  <= 1'b1;
            prev_q       <= phase;
            resync_req_q <= 1'b0;
          end
        end
        default: state_q <= SYNC;
      endcase
    end
  end

  assign idx        = idx_q;
  assign idx_valid  = idx_valid_q;
  assign rev_tick   = rev_tick_q;
  assign rev_cnt    = rev_cnt_q;
  assign err_onehot = err_onehot_q;
  assign err_seq    = err_seq_q;
  assign err_sticky = err_sticky_q;
  assign resync_req = resync_req_q;

endmodule
